sdblk_reader: RTL and testbench
===============================

# sdblk_reader

Block-read sequencer for the SD card SPI path. It accepts a 32-bit block address from the CPU bus and issues CMD17. It then polls R1 and the start token, streams 512 data bytes into an external buffer RAM, consumes the CRC, and releases chip select. It sits between the CPU register bus and the byte-level SPI shift engine, which it drives one byte at a time through a start/done handshake.

## Interface
- R1_TRIES, 8: maximum R1 poll bytes after the command (1..255).
- TOKEN_TRIES, 4096: maximum start-token poll bytes (1..65535).
- clk  in  1  single system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- AD  in  3  register address.
- DI  in  8  write data.
- DO  out  8  read data, registered.
- rw  in  1  1 = read, 0 = write.
- cs  in  1  register select.
- irq  out  1  DONE & IE.
- spi_start  out  1  one-cycle byte-start pulse.
- spi_tx  out  8  byte to send; held stable from spi_start until spi_done.
- spi_done  in  1  one-cycle pulse; spi_rx valid in the same cycle.
- spi_rx  in  8  received byte.
- spi_ss  out  1  card select, active low.
- buf_we  out  1  buffer write strobe.
- buf_addr  out  9  buffer byte index.
- buf_wd  out  8  buffer write data.

## Operation
- Registers:
  - $0 write: bit0 GO, bit1 ABORT, bit7 IE.
  - $0 read: {BUSY, DONE, ERR, IE, 1'b0, ERRCODE[2:0]}.
  - $1..$4: ADDR[31:24]..ADDR[7:0], RW.
  - $5: last R1 byte, RO.
  - $6/$7 reads return 0.
- GO with BUSY=0:
  - clears DONE, ERR, ERRCODE;
  - latches ADDR;
  - enters PRE.
- GO with BUSY=1 is ignored.
- State sequence:
  - IDLE
  - PRE: one 0xFF byte, spi_ss low.
  - CMD: 6 bytes 0x51, A31..A24, A23..A16, A15..A8, A7..A0, 0xFF.
  - R1: send 0xFF until spi_rx[7]==0.
    - rx==0x00 → TOKEN.
    - other valid R1 → error 2.
    - R1_TRIES bytes with bit7 set → error 1.
  - TOKEN: send 0xFF until rx!=0xFF.
    - 0xFE → DATA.
    - other value → error 4.
    - TOKEN_TRIES bytes of 0xFF → error 3.
  - DATA: 512 bytes of 0xFF sent. Each spi_done gives buf_we=1, buf_addr=index, buf_wd=spi_rx for exactly that cycle.
  - CRC: 2 bytes.
  - POST: spi_ss high, one 0xFF byte.
  - IDLE: DONE=1.
- Any error:
  - ERRCODE latched, ERR=1;
  - goes through POST (spi_ss high, one 0xFF), then IDLE with DONE=1.
- ABORT while busy:
  - the in-flight byte completes (waits for spi_done, no buffer write);
  - ERRCODE=6, then POST.
  - ABORT while idle is ignored.
- ERRCODE values: 0 ok, 1 R1 timeout, 2 R1 nonzero, 3 token timeout, 4 data error token, 5 CRC mismatch, 6 aborted.
- BUSY=1 in every state except IDLE.

## Timing
- Reset values:
  - DO=0, irq=0, spi_start=0, spi_tx=0xFF, spi_ss=1, buf_we=0, buf_addr=0, buf_wd=0.
  - ADDR=0, IE=0, DONE=0, ERR=0, ERRCODE=0, R1 register=0xFF, state IDLE.
- Reset mid-transfer forces IDLE and spi_ss=1 on the next edge. The engine's in-flight byte is ignored.
- Register reads: DO updates on the edge where cs&rw=1 and is valid the following cycle. Writes take effect on the edge where cs&!rw=1.
- GO write at edge N:
  - spi_ss=0 from N+1;
  - first spi_start at N+1.
- Byte handshake:
  - next spi_start no earlier than the cycle after spi_done;
  - at most one byte outstanding;
  - spi_done with no outstanding byte is ignored.
- buf_addr wraps only by sequence: 0..511, one write each, no other writes.
- DONE and IE update on the same edge; irq is combinational from them. DONE is cleared only by GO or rst.
- Simultaneous GO and ABORT in one write: ABORT is ignored and GO is honoured if idle. If busy, ABORT is taken.

## Configuration
- SDBLK_CRC_CHECK_EN defined:
  - CRC-16/CCITT (poly 0x1021, init 0x0000) runs over the 512 data bytes;
  - it is compared to the two CRC bytes (MSB first);
  - a mismatch sets ERRCODE=5 before POST.
- Undefined: CRC bytes are read and discarded, no CRC logic, and code 5 never occurs.

## Test plan
- Normal read, ADDR=0x00000010: engine returns R1=0x00 on the 2nd poll, token 0xFE on the 3rd, data i&0xFF, then CRC → command bytes 51 00 00 00 10 FF; 512 buffer writes with buf_wd[i]=i&0xFF; status 0x40 (DONE); spi_ss high after POST.
- R1 never clears (all 0xFF), R1_TRIES=8 → exactly 8 R1 poll bytes, status 0x61 (DONE|ERR|code1), no buffer writes.
- Token 0x05 returned → status 0x64, zero buffer writes, POST byte sent.
- ABORT written during DATA at byte 100 → current byte finishes; 100 writes total, no write for the in-flight byte; ERRCODE 6; spi_ss=1.
- With SDBLK_CRC_CHECK_EN, all-zero data and CRC bytes 0x00 0x01 → ERRCODE 5; with correct CRC 0x0000 → status 0x40.
- rst asserted mid-CMD → next cycle spi_ss=1, status 0x00; a GO during BUSY is ignored (command byte count unchanged).

Source files
------------

// File: rtl/sdblk_reader.sv
// CMD17 single-block read sequencer: drives a byte-wide SPI engine and streams 512 bytes into a buffer RAM.
// Optional CRC-16/CCITT check of the block is compiled in with `define SDBLK_CRC_CHECK_EN.
module sdblk_reader #(
  parameter int R1_TRIES    = 8,
  parameter int TOKEN_TRIES = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] AD,
  input  logic [7:0] DI,
  output logic [7:0] DO,
  input  logic       rw,
  input  logic       cs,
  output logic       irq,
  output logic       spi_start,
  output logic [7:0] spi_tx,
  input  logic       spi_done,
  input  logic [7:0] spi_rx,
  output logic       spi_ss,
  output logic       buf_we,
  output logic [8:0] buf_addr,
  output logic [7:0] buf_wd
);
  typedef enum logic [2:0] {S_IDLE, S_PRE, S_CMD, S_R1, S_TOK, S_DATA, S_CRC, S_POST} state_t;
  localparam logic [2:0] E_R1_TO = 3'd1, E_R1_NZ = 3'd2, E_TOK_TO = 3'd3, E_TOK_BAD = 3'd4, E_ABORT = 3'd6;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        out_q, out_d, abort_q, abort_d, ss_q, ss_d, start_q, start_d;
  logic [7:0]  tx_q, tx_d, r1_q, r1_d, do_q, do_d;
  logic        done_q, done_d, err_q, err_d, ie_q, ie_d;
  logic [2:0]  code_q, code_d;
  logic [31:0] addr_q, addr_d, lat_q, lat_d;
  logic        wr, rd, busy, go, ab_wr, byte_done, abort_now, launch;

`ifdef SDBLK_CRC_CHECK_EN
  localparam logic [2:0] E_CRC = 3'd5;
  logic [15:0] crc_q, crc_d;
  logic [7:0]  crc_hi_q, crc_hi_d;

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction
`endif

  function automatic logic [7:0] cmd_byte(input logic [15:0] idx, input logic [31:0] a);
    case (idx)
      16'd0:   return 8'h51;
      16'd1:   return a[31:24];
      16'd2:   return a[23:16];
      16'd3:   return a[15:8];
      16'd4:   return a[7:0];
      default: return 8'hFF;
    endcase
  endfunction

  assign wr        = cs & ~rw;
  assign rd        = cs & rw;
  assign busy      = (state_q != S_IDLE);
  assign go        = wr && (AD == 3'd0) && DI[0] && !busy;
  assign ab_wr     = wr && (AD == 3'd0) && DI[1];
  assign byte_done = spi_done & out_q;
  // An abort written in the very cycle a byte finishes still suppresses that byte's buffer write.
  assign abort_now = (abort_q | ab_wr) & busy & (state_q != S_POST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE; cnt_q <= '0; out_q <= 1'b0; abort_q <= 1'b0;
      ss_q <= 1'b1; start_q <= 1'b0; tx_q <= 8'hFF; r1_q <= 8'hFF; do_q <= 8'h00;
      done_q <= 1'b0; err_q <= 1'b0; ie_q <= 1'b0; code_q <= 3'd0;
      addr_q <= '0; lat_q <= '0;
`ifdef SDBLK_CRC_CHECK_EN
      crc_q <= '0; crc_hi_q <= '0;
`endif
    end else begin
      state_q <= state_d; cnt_q <= cnt_d; out_q <= out_d; abort_q <= abort_d;
      ss_q <= ss_d; start_q <= start_d; tx_q <= tx_d; r1_q <= r1_d; do_q <= do_d;
      done_q <= done_d; err_q <= err_d; ie_q <= ie_d; code_q <= code_d;
      addr_q <= addr_d; lat_q <= lat_d;
`ifdef SDBLK_CRC_CHECK_EN
      crc_q <= crc_d; crc_hi_q <= crc_hi_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q; cnt_d = cnt_q; abort_d = abort_q;
    done_d = done_q; err_d = err_q; code_d = code_q; ie_d = ie_q;
    r1_d = r1_q; addr_d = addr_q; lat_d = lat_q;
`ifdef SDBLK_CRC_CHECK_EN
    crc_d = crc_q; crc_hi_d = crc_hi_q;
`endif
    if (wr) begin
      case (AD)
        3'd0: ie_d = DI[7];
        3'd1: addr_d[31:24] = DI;
        3'd2: addr_d[23:16] = DI;
        3'd3: addr_d[15:8]  = DI;
        3'd4: addr_d[7:0]   = DI;
        default: ;
      endcase
    end
    if (ab_wr && busy && state_q != S_POST) abort_d = 1'b1;

    if (go) begin
      done_d = 1'b0; err_d = 1'b0; code_d = 3'd0; abort_d = 1'b0;
      lat_d = addr_q; state_d = S_PRE; cnt_d = '0;
`ifdef SDBLK_CRC_CHECK_EN
      crc_d = '0;
`endif
    end else if (byte_done) begin
      if (abort_now) begin
        state_d = S_POST; err_d = 1'b1; code_d = E_ABORT;
      end else begin
        case (state_q)
          S_PRE: begin state_d = S_CMD; cnt_d = '0; end
          S_CMD: begin
            cnt_d = cnt_q + 16'd1;
            if (cnt_q == 16'd5) begin state_d = S_R1; cnt_d = '0; end
          end
          S_R1: begin
            r1_d  = spi_rx;
            cnt_d = cnt_q + 16'd1;
            if (!spi_rx[7]) begin
              if (spi_rx == 8'h00) begin state_d = S_TOK; cnt_d = '0; end
              else begin state_d = S_POST; err_d = 1'b1; code_d = E_R1_NZ; end
            end else if (cnt_q == 16'(R1_TRIES - 1)) begin
              state_d = S_POST; err_d = 1'b1; code_d = E_R1_TO;
            end
          end
          S_TOK: begin
            cnt_d = cnt_q + 16'd1;
            if (spi_rx == 8'hFE) begin state_d = S_DATA; cnt_d = '0; end
            else if (spi_rx != 8'hFF) begin state_d = S_POST; err_d = 1'b1; code_d = E_TOK_BAD; end
            else if (cnt_q == 16'(TOKEN_TRIES - 1)) begin
              state_d = S_POST; err_d = 1'b1; code_d = E_TOK_TO;
            end
          end
          S_DATA: begin
            cnt_d = cnt_q + 16'd1;
`ifdef SDBLK_CRC_CHECK_EN
            crc_d = crc_byte(crc_q, spi_rx);
`endif
            if (cnt_q == 16'd511) begin state_d = S_CRC; cnt_d = '0; end
          end
          S_CRC: begin
            cnt_d = 16'd1;
            if (cnt_q != 16'd0) begin
              state_d = S_POST;
`ifdef SDBLK_CRC_CHECK_EN
              if ({crc_hi_q, spi_rx} != crc_q) begin err_d = 1'b1; code_d = E_CRC; end
`endif
            end
`ifdef SDBLK_CRC_CHECK_EN
            else crc_hi_d = spi_rx;
`endif
          end
          S_POST: begin state_d = S_IDLE; done_d = 1'b1; end
          default: state_d = S_IDLE;
        endcase
      end
      if (state_d == S_POST || state_d == S_IDLE) begin
        abort_d = 1'b0;
        if (state_q != S_POST) cnt_d = '0;
      end
    end
  end

  always_comb begin
    // Next byte is issued on the same edge the previous one completes, so a byte is always in flight while busy.
    launch  = go | (byte_done & (state_d != S_IDLE));
    start_d = launch;
    out_d   = launch ? 1'b1 : (byte_done ? 1'b0 : out_q);
    tx_d    = tx_q;
    if (launch) tx_d = (state_d == S_CMD) ? cmd_byte(cnt_d, lat_d) : 8'hFF;
    ss_d = (state_d == S_IDLE) || (state_d == S_POST);
    do_d = do_q;
    if (rd) begin
      case (AD)
        3'd0:    do_d = {busy, done_q, err_q, ie_q, 1'b0, code_q};
        3'd1:    do_d = addr_q[31:24];
        3'd2:    do_d = addr_q[23:16];
        3'd3:    do_d = addr_q[15:8];
        3'd4:    do_d = addr_q[7:0];
        3'd5:    do_d = r1_q;
        default: do_d = 8'h00;
      endcase
    end
    buf_we   = (state_q == S_DATA) & byte_done & ~abort_now;
    buf_addr = (state_q == S_DATA) ? cnt_q[8:0] : 9'd0;
    buf_wd   = buf_we ? spi_rx : 8'h00;
  end

  assign DO        = do_q;
  assign irq       = done_q & ie_q;
  assign spi_start = start_q;
  assign spi_tx    = tx_q;
  assign spi_ss    = ss_q;
endmodule

// File: tb/tb_sdblk_reader.sv
// Bench for sdblk_reader: scripted SPI card/engine model, buffer monitor and an arithmetic outcome model.
module tb_sdblk_reader;
  localparam int R1T = 8, TT = 4096;

  logic       clk = 1'b0, rst = 1'b1;
  logic [2:0] AD = '0;
  logic [7:0] DI = '0;
  logic [7:0] DO;
  logic       rw = 1'b1, cs = 1'b0;
  logic       irq, spi_start, spi_ss, buf_we;
  logic [7:0] spi_tx, buf_wd;
  logic       spi_done = 1'b0;
  logic [7:0] spi_rx = '0;
  logic [8:0] buf_addr;

  sdblk_reader #(.R1_TRIES(R1T), .TOKEN_TRIES(TT)) dut (
    .clk(clk), .rst(rst), .AD(AD), .DI(DI), .DO(DO), .rw(rw), .cs(cs), .irq(irq),
    .spi_start(spi_start), .spi_tx(spi_tx), .spi_done(spi_done), .spi_rx(spi_rx),
    .spi_ss(spi_ss), .buf_we(buf_we), .buf_addr(buf_addr), .buf_wd(buf_wd));

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  logic [7:0] script[$], txlog[$], wdq[$];
  logic       sslog[$];
  int         wa[$];
  int         lat_max = 2;
  bit         hold_en = 1'b1;

  // Card + byte engine: answers each spi_start from the script (0xFF when exhausted).
  initial begin
    logic [7:0] t;
    @(negedge clk);
    forever begin
      if (spi_start) begin
        t = spi_tx;
        txlog.push_back(spi_tx);
        sslog.push_back(spi_ss);
        repeat ($urandom_range(1, lat_max)) @(negedge clk);
        if (hold_en) chk("txhold", spi_tx, t);
        spi_rx   = (script.size() > 0) ? script.pop_front() : 8'hFF;
        spi_done = 1'b1;
        @(negedge clk);
        spi_done = 1'b0;
        spi_rx   = 8'h00;
      end else @(negedge clk);
    end
  end

  always @(negedge clk) begin
    #1;
    if (buf_we) begin
      wa.push_back(int'(buf_addr));
      wdq.push_back(buf_wd);
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk); cs = 1'b1; rw = 1'b0; AD = a; DI = d;
    @(negedge clk); cs = 1'b0; rw = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [7:0] d);
    @(negedge clk); cs = 1'b1; rw = 1'b1; AD = a;
    @(negedge clk); cs = 1'b0; d = DO;
  endtask

`ifdef SDBLK_CRC_CHECK_EN
  function automatic logic [15:0] crc_ref(input logic [7:0] d[512]);
    logic [15:0] c;
    bit fb;
    c = 16'h0000;
    for (int i = 0; i < 512; i++)
      for (int b = 7; b >= 0; b--) begin
        fb = c[15] ^ d[i][b];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h1021;
      end
    return c;
  endfunction
`endif

  task automatic run_xfer(input string nm, input logic [31:0] addr, input int r1d, input logic [7:0] r1v,
                          input int tkd, input logic [7:0] tkv, input int pat, input bit crc_bad,
                          input int abort_at, input bit ie, input bit go_again);
    logic [7:0]  data[512];
    logic [7:0]  cmd[7];
    logic [15:0] crc;
    logic [7:0]  st, r1exp, e;
    int code, nb, nw, bad, n;
    for (int i = 0; i < 512; i++)
      data[i] = (pat == 0) ? 8'(i) : (pat == 1) ? 8'($urandom) : 8'h00;
`ifdef SDBLK_CRC_CHECK_EN
    crc = crc_ref(data);
`else
    crc = 16'($urandom);
`endif
    if (crc_bad) crc = crc ^ 16'h0001;
    cmd = '{8'hFF, 8'h51, addr[31:24], addr[23:16], addr[15:8], addr[7:0], 8'hFF};
    script.delete(); txlog.delete(); sslog.delete(); wa.delete(); wdq.delete();
    hold_en = 1'b1;

    repeat (7) script.push_back(8'hFF);
    code = 0; nb = 7; nw = 0; r1exp = 8'hFF;
    repeat (r1d) script.push_back(8'hFF);
    if (r1d >= R1T) begin nb += R1T; code = 1; end
    else begin
      script.push_back(r1v); nb += r1d + 1; r1exp = r1v;
      if (r1v != 8'h00) code = 2;
      else if (tkd >= TT) begin nb += TT; code = 3; end
      else begin
        repeat (tkd) script.push_back(8'hFF);
        script.push_back(tkv); nb += tkd + 1;
        if (tkv != 8'hFE) code = 4;
        else begin
          for (int i = 0; i < 512; i++) script.push_back(data[i]);
          script.push_back(crc[15:8]); script.push_back(crc[7:0]);
          if (abort_at >= 0) begin nb += abort_at + 1; nw = abort_at; code = 6; end
          else begin
            nb += 514; nw = 512;
`ifdef SDBLK_CRC_CHECK_EN
            if (crc_bad) code = 5;
`endif
          end
        end
      end
    end
    nb += 1;

    wr(3'd1, addr[31:24]); wr(3'd2, addr[23:16]); wr(3'd3, addr[15:8]); wr(3'd4, addr[7:0]);
    wr(3'd0, {ie, 6'b0, 1'b1});
    chk({nm, ".ss_low"}, spi_ss, 1'b0);
    chk({nm, ".start1"}, spi_start, 1'b1);
    if (go_again) begin
      repeat (3) @(negedge clk);
      wr(3'd0, {ie, 6'b0, 1'b1});
    end
    if (abort_at >= 0) begin
      n = 0;
      while (wa.size() < abort_at && n < 20000) begin @(negedge clk); n++; end
      if (n >= 20000) chk({nm, ".abort_wait"}, 1, 0);
      wr(3'd0, {ie, 5'b0, 2'b10});
    end
    n = 0;
    do begin rd(3'd0, st); n++; end while (st[7] && n < 30000);
    if (st[7]) chk({nm, ".busy_timeout"}, 1, 0);
    repeat (4) @(negedge clk);

    chk({nm, ".status"}, st, {1'b0, 1'b1, code != 0, ie, 1'b0, 3'(code)});
    chk({nm, ".irq"}, irq, ie);
    chk({nm, ".ntx"}, txlog.size(), nb);
    bad = 0;
    for (int i = 0; i < txlog.size(); i++) begin
      e = (i < 7) ? cmd[i] : 8'hFF;
      if (txlog[i] !== e) bad++;
      if (sslog[i] !== (i == txlog.size() - 1)) bad++;
    end
    chk({nm, ".txseq_bad"}, bad, 0);
    chk({nm, ".nwrites"}, wa.size(), nw);
    bad = 0;
    for (int i = 0; i < wa.size(); i++)
      if (wa[i] != i || wdq[i] !== data[i]) bad++;
    chk({nm, ".wdata_bad"}, bad, 0);
    chk({nm, ".ss_high"}, spi_ss, 1'b1);
    rd(3'd5, st);
    chk({nm, ".r1reg"}, st, r1exp);
  endtask

  initial begin
    logic [7:0] st;
    int n, kind, r1d, tkd;
    logic [7:0] r1v, tkv;
    repeat (3) @(negedge clk);
    chk("rst.DO", DO, 8'h00);        chk("rst.irq", irq, 1'b0);
    chk("rst.start", spi_start, 1'b0); chk("rst.tx", spi_tx, 8'hFF);
    chk("rst.ss", spi_ss, 1'b1);     chk("rst.we", buf_we, 1'b0);
    chk("rst.baddr", buf_addr, 9'd0); chk("rst.bwd", buf_wd, 8'h00);
    rst = 1'b0;
    rd(3'd0, st); chk("rst.status", st, 8'h00);
    rd(3'd5, st); chk("rst.r1reg", st, 8'hFF);
    rd(3'd6, st); chk("rst.reg6", st, 8'h00);
    rd(3'd4, st); chk("rst.addr0", st, 8'h00);

    run_xfer("norm", 32'h0000_0010, 1, 8'h00, 2, 8'hFE, 0, 1'b0, -1, 1'b0, 1'b1);
    run_xfer("r1to", $urandom, R1T, 8'h00, 0, 8'hFE, 1, 1'b0, -1, 1'b0, 1'b0);
    run_xfer("tokerr", $urandom, 0, 8'h00, 0, 8'h05, 1, 1'b0, -1, 1'b0, 1'b0);
    run_xfer("r1nz", $urandom, 3, 8'h04, 0, 8'hFE, 1, 1'b0, -1, 1'b1, 1'b0);
    lat_max = 3;
    run_xfer("abort", $urandom, 0, 8'h00, 0, 8'hFE, 1, 1'b0, 100, 1'b1, 1'b0);
    lat_max = 1;
    run_xfer("tokto", $urandom, 0, 8'h00, TT, 8'hFE, 1, 1'b0, -1, 1'b0, 1'b0);
    lat_max = 2;
`ifdef SDBLK_CRC_CHECK_EN
    run_xfer("crcbad", $urandom, 0, 8'h00, 0, 8'hFE, 2, 1'b1, -1, 1'b0, 1'b0);
    run_xfer("crcok", $urandom, 0, 8'h00, 0, 8'hFE, 2, 1'b0, -1, 1'b0, 1'b0);
`endif

    // Reset in the middle of the command bytes.
    script.delete(); txlog.delete(); sslog.delete();
    wr(3'd0, 8'h81);
    n = 0;
    while (txlog.size() < 3 && n < 200) begin @(negedge clk); n++; end
    hold_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid.ss", spi_ss, 1'b1);
    chk("rstmid.start", spi_start, 1'b0);
    rst = 1'b0;
    rd(3'd0, st); chk("rstmid.status", st, 8'h00);
    chk("rstmid.irq", irq, 1'b0);
    rd(3'd1, st); chk("rstmid.addr", st, 8'h00);
    repeat (10) @(negedge clk);
    chk("rstmid.no_more_bytes", txlog.size(), 3);

    for (int it = 0; it < 8; it++) begin
      kind = $urandom_range(0, 5);
      r1d = $urandom_range(0, R1T - 1); r1v = 8'h00;
      tkd = $urandom_range(0, 20);      tkv = 8'hFE;
      case (kind)
        3: r1v = 8'($urandom_range(1, 127));
        4: r1d = $urandom_range(R1T - 2, R1T);
        5: tkv = 8'($urandom_range(0, 253));
        default: ;
      endcase
      run_xfer($sformatf("rnd%0d", it), $urandom, r1d, r1v, tkd, tkv, 1,
               $urandom_range(0, 3) == 0, -1, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
